data_sram_responder: RTL
========================

// Module: data_sram_responder
// PURPOSE
//  Responder end of the CPU data-SRAM port: accepts en/we/addr/wdata from the core's EXE stage and
//  returns data_sram_rdata one cycle later for the MEM stage. Backs a word-addressed RAM and a small
//  MMIO window (LED, switches, free-running timer, scratch). Sits beside the core in the SoC top.
// PARAMETERS
//  RAM_AW     12             RAM word-address width (2**RAM_AW 32-bit words)
//  CONF_BASE  32'hBFAF_0000  MMIO window base; window = addr[31:16]==CONF_BASE[31:16]
// PORTS
//  clk              in   1   clock, all state on rising edge
//  resetn           in   1   asynchronous, active-low reset
//  data_sram_en     in   1   access request this cycle
//  data_sram_we     in   4   byte write enables; 0 = read, nonzero = write
//  data_sram_addr   in   32  byte address; addr[1:0] ignored
//  data_sram_wdata  in   32  write data, lane i = wdata[8i+7:8i]
//  data_sram_rdata  out  32  read data, valid the cycle after the read request
//  led              out  16  LED register
//  switch           in   8   asynchronous switch inputs
// BEHAVIOUR
//  Reset (async, resetn=0): rdata=0, led=0, timer=0, scratch=0, switch sync flops=0.
//   RAM contents not reset. An access sampled at the edge where reset asserts is dropped.
//  Access: sampled at rising edge when en=1. Read (we==0): rdata <= selected word, visible the next
//   cycle (1-cycle latency, zero-wait; the core never stalls on this port).
//   Write (we!=0): merge only enabled byte lanes into target; rdata unchanged. en=0: rdata holds.
//  Decode: MMIO window -> register map below; else RAM word index = addr[RAM_AW+1:2], upper bits
//   ignored (aliasing is intended).
//  MMIO map (offset = addr[15:0]):
//   0xF000 LED     rw, bits[15:0]; bits[31:16] read 0, writes to lanes 2/3 ignored
//   0xF004 SWITCH  ro, {24'b0, switch_sync}; writes ignored
//   0xE000 TIMER   rw, 32-bit, +1 every cycle, wraps 0xFFFF_FFFF -> 0
//   0xF010 SCRATCH rw, 32-bit
//   other offsets read 0, writes ignored
//  Timer: read returns value before the sampling edge. Write in cycle t: merged value loaded,
//   no increment that cycle; increments resume at t+1. Partial write merges with pre-increment value.
//  Switch: 2-flop synchronizer; SWITCH read reflects input 2 edges earlier.
//  Back-to-back: write A at t then read A at t+1 returns new data at t+2 (no bypass needed,
//   write lands at edge t). Consecutive reads each return at next cycle; no buffering beyond rdata.
//  Combinational paths from inputs to rdata: none (rdata is a flop).
// TESTING
//  1 RAM rw: write 0x1234_5678 to 0x0000_0040 we=4'hF, read next cycle -> rdata=0x1234_5678 one
//    cycle after read request.
//  2 Byte lanes: preload 0xAABB_CCDD, write wdata=0x1122_3344 we=4'b0101 -> read 0xAA22_CC44.
//  3 Timer: hold idle 10 cycles after reset, read 0xBFAF_E000 -> value = cycles since reset release;
//    write 0xFFFF_FFFE, read over 3 cycles -> observe wrap 0xFFFF_FFFF -> 0x0000_0000.
//  4 MMIO: write 0xDEAD_BEEF to LED -> led=16'hBEEF, read LED=0x0000_BEEF; switch=8'h5A, read SWITCH
//    after 2+ cycles -> 0x5A; read offset 0xF100 -> 0; write to SWITCH leaves it 0x5A.
//  5 Aliasing/hold: write 0x77 to RAM word 0, read addr (2**RAM_AW)*4 -> 0x77; en=0 for 5 cycles ->
//    rdata stays 0x77.
//  6 Reset mid-traffic: assert resetn=0 between clock edges during write stream -> rdata, led, timer,
//    scratch go 0 immediately; after release, timer restarts from 0.

Source files
------------

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data-SRAM port responder: word RAM plus MMIO window (LED, switch, timer, scratch)
// All reads return through a single rdata flop one cycle after the request.
module data_sram_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] CONF_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_SCRATCH = 16'hF010;

  logic [31:0]       mem [2**RAM_AW];
  logic [31:0]       timer;
  logic [31:0]       scratch;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic [31:0]       mmio_rdata;
  logic              is_mmio;
  logic              rd;
  logic              wr;
  logic [15:0]       reg_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_lsb;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign is_mmio         = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign reg_off         = {data_sram_addr[15:2], 2'b00};
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign rd              = data_sram_en && (data_sram_we == 4'h0);
  assign wr              = data_sram_en && (data_sram_we != 4'h0);
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  always_comb begin
    mmio_rdata = 32'h0;
    case (reg_off)
      OFF_LED:     mmio_rdata = {16'h0, led};
      OFF_SWITCH:  mmio_rdata = {24'h0, sw_sync};
      OFF_TIMER:   mmio_rdata = timer;
      OFF_SCRATCH: mmio_rdata = scratch;
      default:     mmio_rdata = 32'h0;
    endcase
  end

  // RAM is not reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (resetn && wr && !is_mmio) begin
      mem[ram_idx] <= merge(mem[ram_idx], data_sram_wdata, data_sram_we);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_rdata <= 32'h0;
      led             <= 16'h0;
      timer           <= 32'h0;
      scratch         <= 32'h0;
      sw_meta         <= 8'h0;
      sw_sync         <= 8'h0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;

      // a timer write replaces that cycle's increment
      if (wr && is_mmio && reg_off == OFF_TIMER) begin
        timer <= merge(timer, data_sram_wdata, data_sram_we);
      end else begin
        timer <= timer + 32'd1;
      end

      if (wr && is_mmio && reg_off == OFF_LED) begin
        if (data_sram_we[0]) led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_we[1]) led[15:8] <= data_sram_wdata[15:8];
      end

      if (wr && is_mmio && reg_off == OFF_SCRATCH) begin
        scratch <= merge(scratch, data_sram_wdata, data_sram_we);
      end

      if (rd) begin
        data_sram_rdata <= is_mmio ? mmio_rdata : mem[ram_idx];
      end
    end
  end

endmodule
